mcycle_iter: RTL and testbench
==============================

// Module: mcycle_iter
// PURPOSE
//  Iterative multi-cycle multiply/divide unit; consumes the gated M_Start from the condition-logic stage.
//  Executes MUL/DIV (signed/unsigned) over WIDTH cycles. Busy stalls the fetch/execute path until results are valid.
//  Result1/Result2 are written back through the normal register-write path once Busy falls.
// PARAMETERS
//  WIDTH   32   operand/result width in bits; must be >= 4
// PORTS
//  CLK        in   1      system clock, rising edge
//  RESETn     in   1      asynchronous, active-low reset
//  Start      in   1      M_Start from condition logic; already gated by CondEx
//  MCycleOp   in   2      00 signed MUL, 01 unsigned MUL, 10 signed DIV, 11 unsigned DIV
//  Operand1   in   WIDTH  multiplicand / dividend
//  Operand2   in   WIDTH  multiplier / divisor
//  Result1    out  WIDTH  product low half / quotient
//  Result2    out  WIDTH  product high half / remainder
//  Busy       out  1      high while the operation is pending; stalls the PC and pipeline
// BEHAVIOUR
//  - Reset (RESETn=0, asynchronous): state=IDLE, count=0, Result1=Result2=0, Busy=0. Busy is forced 0 while reset is held.
//  - States: IDLE -> COMPUTE -> DONE -> IDLE.
//  - IDLE: Busy = Start (combinational, same cycle), so the issuing instruction stalls immediately.
//    On the edge where Start=1, latch Operand1, Operand2 and MCycleOp, set count=0, and go to COMPUTE.
//  - COMPUTE: Busy=1. One radix-2 step per cycle; count increments from 0 to WIDTH-1.
//    At the edge with count==WIDTH-1: Result1/Result2 are registered (sign fix-up applied), then go to DONE.
//  - DONE: Busy=0 for exactly one cycle. Start is ignored here, because the stalled instruction re-presents Start.
//    Then go to IDLE unconditionally.
//  - Latency: Start in cycle 0 gives Busy high in cycles 0..WIDTH (WIDTH+1 cycles). Results are valid and Busy is low in cycle WIDTH+1.
//  - Results hold their value until the next completion; they do not change in IDLE.
//  - Operands and MCycleOp changing after cycle 0 have no effect. Start asserted during COMPUTE is ignored.
//  - MUL: shift-add on magnitudes, 2*WIDTH-bit product {Result2,Result1}.
//    Signed: magnitudes |Op1|, |Op2|; negate the 2*WIDTH product if the operand signs differ.
//  - DIV: restoring division on magnitudes; a WIDTH+1-bit partial remainder handles the borrow.
//    Signed: quotient negated if signs differ; remainder takes the sign of the dividend (truncating division).
//  - Divide by zero (any signedness): Result1 = all ones, Result2 = Operand1. Same WIDTH+1 latency.
//  - Signed MIN / -1: Result1 = MIN (0x80000000 for WIDTH=32), Result2 = 0. No trap.
//  - |MIN| = 2^(WIDTH-1) is representable unsigned in WIDTH bits. The magnitude path needs no extra bit beyond the divider remainder.
//  - Reset mid-operation: abort immediately to IDLE with results cleared. No partial result is ever visible.
// STRUCTURE
//  - Shared package mcycle_pkg:
//    MCycleOp encodings (OP_SMUL, OP_UMUL, OP_SDIV, OP_UDIV).
//    State encoding (ST_IDLE, ST_COMPUTE, ST_DONE).
//    Divide-by-zero result constant.
//  - Top level: FSM, counter, operand latch, sign pre/post-processing.
//  - One sub-module, mcycle_core: unsigned datapath doing one shift-add or one restoring-subtract step per enable.
//    Registers: 2*WIDTH accumulator and WIDTH+1 remainder.
// TESTING
//  - Signed MUL 7 x -3 -> after 33 cycles Result1=0xFFFFFFEB, Result2=0xFFFFFFFF.
//  - Unsigned MUL 0xFFFFFFFF x 2 -> Result1=0xFFFFFFFE, Result2=0x00000001.
//  - Signed DIV -7 / 2 -> Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFF (-1).
//  - Unsigned DIV 100 / 7 -> Result1=14, Result2=2.
//  - DIV 5 / 0 -> Result1=0xFFFFFFFF, Result2=5. Signed 0x80000000 / -1 -> Result1=0x80000000, Result2=0.
//  - Timing: Start held high from cycle 0 -> Busy high in cycles 0..32, low in cycle 33.
//    Busy stays low in cycle 33 even though Start is still high. Busy rises again in cycle 34 if Start is still high.
//  - Reset mid-op: RESETn low at cycle 10 -> Busy=0 and Results=0 immediately.
//    After release, a fresh Start completes normally.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   mcycle_op_e    : operation encoding presented on MCycleOp
//   mcycle_state_e : controller state encoding
//   DIV0_FILL      : bit replicated across the quotient on a zero divisor
package mcycle_pkg;

    typedef enum logic [1:0] {
        OP_SMUL = 2'b00,
        OP_UMUL = 2'b01,
        OP_SDIV = 2'b10,
        OP_UDIV = 2'b11
    } mcycle_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_DONE    = 2'b10
    } mcycle_state_e;

    // Quotient on divide-by-zero is all ones (remainder returns the dividend).
    localparam logic DIV0_FILL = 1'b1;

    function automatic logic op_is_signed(input mcycle_op_e op);
        return (op == OP_SMUL) || (op == OP_SDIV);
    endfunction

    function automatic logic op_is_div(input mcycle_op_e op);
        return (op == OP_SDIV) || (op == OP_UDIV);
    endfunction

endpackage

// File: rtl/mcycle_iter_core.sv
// Unsigned radix-2 datapath: one shift-add (MUL) or one restoring subtract
// (DIV) step per cycle with step high.
//   load      : capture magnitudes a (multiplier/dividend) and b (multiplicand/divisor)
//   step      : perform one iteration
//   is_div    : select divide step instead of multiply step
//   prod_next : value the accumulator takes on this step (product, or quotient in low half)
//   rem_next  : value the remainder takes on this step (low WIDTH bits)
// The *_next outputs let the parent register the final result on the same
// edge as the last step.
module mcycle_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod_next,
    output logic [WIDTH-1:0]     rem_next
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   b_q;

    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH:0]     rem_nx;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               borrow;

    always_comb begin
        acc_nx  = acc;
        rem_nx  = rem;
        // Multiply: add multiplicand into the high half when the current
        // multiplier bit is set; the carry is kept by shifting right.
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
        // Divide: dividend bits shift out of the low half into the partial
        // remainder. The remainder's top bit is dropped by the shift because
        // it is always clear after a step (remainder < divisor).
        shifted = (rem << 1) | (WIDTH+1)'(acc[WIDTH-1]);
        diff    = shifted - {1'b0, b_q};
        borrow  = shifted < {1'b0, b_q};
        if (is_div) begin
            rem_nx            = borrow ? shifted : diff;
            acc_nx[WIDTH-1:0] = {acc[WIDTH-2:0], ~borrow};
        end else begin
            acc_nx = {sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            acc <= '0;
            rem <= '0;
            b_q <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, a};
            rem <= '0;
            b_q <= b;
        end else if (step) begin
            acc <= acc_nx;
            rem <= rem_nx;
        end
    end

    assign prod_next = acc_nx;
    assign rem_next  = rem_nx[WIDTH-1:0];

endmodule

// File: rtl/mcycle_iter.sv
// Iterative multiply/divide unit. Start launches an operation; Busy stalls
// the pipeline until Result1/Result2 are valid (WIDTH+1 busy cycles).
//   CLK, RESETn        : clock, asynchronous active-low reset
//   Start, MCycleOp    : launch strobe and operation select
//   Operand1, Operand2 : multiplicand/dividend, multiplier/divisor
//   Result1, Result2   : product low/high, or quotient/remainder
//   Busy               : operation pending
//
// state      | meaning
// ST_IDLE    | waiting; Busy follows Start, Start latches operands
// ST_COMPUTE | one radix-2 step per cycle, count 0..WIDTH-1
// ST_DONE    | results valid, Busy low for one cycle, Start ignored
module mcycle_iter
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              Start,
    input  logic [1:0]        MCycleOp,
    input  logic [WIDTH-1:0]  Operand1,
    input  logic [WIDTH-1:0]  Operand2,
    output logic [WIDTH-1:0]  Result1,
    output logic [WIDTH-1:0]  Result2,
    output logic              Busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mcycle_state_e state, state_next;
    logic [CW-1:0] count;
    logic          load, step, busy;

    mcycle_op_e       in_op, op_q;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_q, rem_neg_q, div0_q;
    logic [WIDTH-1:0] op1_q;

    logic [2*WIDTH-1:0] prod_next, prod_fix;
    logic [WIDTH-1:0]   rem_next, quo_fix, rem_fix;
    logic [WIDTH-1:0]   res1_nx, res2_nx;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = Start;
                load = Start;
                if (Start) state_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == LAST) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        // Start is combinational in IDLE, so gate it explicitly during reset.
        if (!RESETn) busy = 1'b0;
    end

    assign Busy = busy;

    // Magnitudes feed the unsigned core; |MIN| fits as an unsigned WIDTH value.
    always_comb begin
        in_op = mcycle_op_e'(MCycleOp);
        a_neg = op_is_signed(in_op) & Operand1[WIDTH-1];
        b_neg = op_is_signed(in_op) & Operand2[WIDTH-1];
        a_mag = a_neg ? -Operand1 : Operand1;
        b_mag = b_neg ? -Operand2 : Operand2;
    end

    mcycle_iter_core #(.WIDTH(WIDTH)) u_core (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .load      (load),
        .step      (step),
        .is_div    (op_is_div(op_q)),
        .a         (a_mag),
        .b         (b_mag),
        .prod_next (prod_next),
        .rem_next  (rem_next)
    );

    // Sign fix-up: product/quotient negated on differing signs, remainder
    // follows the dividend (truncating division).
    always_comb begin
        prod_fix = neg_q ? -prod_next : prod_next;
        quo_fix  = neg_q ? -prod_next[WIDTH-1:0] : prod_next[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -rem_next : rem_next;
        if (op_is_div(op_q)) begin
            if (div0_q) begin
                res1_nx = {WIDTH{DIV0_FILL}};
                res2_nx = op1_q;
            end else begin
                res1_nx = quo_fix;
                res2_nx = rem_fix;
            end
        end else begin
            res1_nx = prod_fix[WIDTH-1:0];
            res2_nx = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            count     <= '0;
            op_q      <= OP_SMUL;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            op1_q     <= '0;
            Result1   <= '0;
            Result2   <= '0;
        end else begin
            if (load) begin
                count     <= '0;
                op_q      <= in_op;
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                div0_q    <= (Operand2 == '0);
                op1_q     <= Operand1;
            end else if (step) begin
                count <= count + CW'(1);
            end
            if (step && count == LAST) begin
                Result1 <= res1_nx;
                Result2 <= res2_nx;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_iter.sv
// Scoreboard bench for mcycle_iter (WIDTH=32): stimulus pushes expected
// results from a 64-bit arithmetic model; a monitor pops and compares on
// every falling edge of Busy.
module tb_mcycle_iter;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
    } exp_t;

    logic         CLK;
    logic         RESETn;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1, Operand2;
    logic [W-1:0] Result1, Result2;
    logic         Busy;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    mcycle_iter #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with truncating signed division.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = 64'h0;
        case (op)
            2'b00: begin p = sa * sb; e.r1 = p[31:0]; e.r2 = p[63:32]; end
            2'b01: begin p = ua * ub; e.r1 = p[31:0]; e.r2 = p[63:32]; end
            2'b10: begin
                if (b == 0) begin e.r1 = '1; e.r2 = a; end
                else begin sq = sa / sb; sr = sa % sb; e.r1 = sq[31:0]; e.r2 = sr[31:0]; end
            end
            default: begin
                if (b == 0) begin e.r1 = '1; e.r2 = a; end
                else begin p = ua / ub; e.r1 = p[31:0]; p = ua % ub; e.r2 = p[31:0]; end
            end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: results are checked in the cycle Busy falls.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                prev = 1'b0;
            end else begin
                if (prev && !Busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: results 0x%0h/0x%0h with no pending op", Result1, Result2);
                    end else begin
                        e = exp_q.pop_front();
                        check("result1", 64'(Result1), 64'(e.r1));
                        check("result2", 64'(Result2), 64'(e.r2));
                    end
                end
                prev = Busy;
            end
        end
    end

    // One operation with Start for a single cycle; operands scrambled after
    // cycle 0 and a stray Start pulse during COMPUTE must have no effect.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        logic glitch;
        glitch = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        e = model(op, a, b);
        exp_q.push_back(e);
        @(negedge CLK);
        check("busy_same_cycle", 64'(Busy), 64'd1);
        n = 1;
        for (int c = 1; c < 200; c++) begin
            @(posedge CLK); #1;
            Start = (c == 5) ? glitch : 1'b0;
            if (c == 1) begin
                MCycleOp = 2'($urandom); Operand1 = 32'($urandom); Operand2 = 32'($urandom);
            end
            @(negedge CLK);
            if (!Busy) break;
            n++;
        end
        check("busy_length", 64'(n), 64'(W + 1));
        repeat (3) @(negedge CLK);
        check("hold_result1", 64'(Result1), 64'(e.r1));
        check("hold_result2", 64'(Result2), 64'(e.r2));
    endtask

    initial begin
        exp_t e;
        RESETn = 1'b0; Start = 1'b1; MCycleOp = 2'b00;
        Operand1 = 32'd7; Operand2 = 32'd3;
        #1;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_result1", 64'(Result1), 64'd0);
        check("reset_result2", 64'(Result2), 64'd0);
        repeat (2) @(posedge CLK);
        #1; Start = 1'b0; RESETn = 1'b1;

        run_op(2'b00, 32'd7, -32'd3);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
        run_op(2'b10, -32'd7, 32'd2);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b11, 32'd5, 32'd0);
        run_op(2'b10, 32'd5, 32'd0);
        run_op(2'b10, -32'd5, 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        // Start held: DONE ignores it, the next IDLE cycle relaunches.
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd3; Operand2 = 32'd5;
        exp_q.push_back(model(2'b01, 32'd3, 32'd5));
        exp_q.push_back(model(2'b01, 32'd3, 32'd5));
        for (int c = 0; c <= W + 2; c++) begin
            @(negedge CLK);
            check($sformatf("held_busy_c%0d", c), 64'(Busy), 64'((c <= W) || (c == W + 2)));
            if (c < W + 2) @(posedge CLK);
        end
        @(posedge CLK); #1;
        Start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!Busy) break;
        end
        check("held_second_done", 64'(Busy), 64'd0);
        repeat (2) @(negedge CLK);

        // Reset mid-operation.
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd1234; Operand2 = 32'd5678;
        exp_q.push_back(model(2'b00, 32'd1234, 32'd5678));
        repeat (10) begin
            @(posedge CLK); #1;
            Start = 1'b0;
        end
        RESETn = 1'b0;
        Start  = 1'b1;
        #1;
        check("midreset_busy", 64'(Busy), 64'd0);
        check("midreset_result1", 64'(Result1), 64'd0);
        check("midreset_result2", 64'(Result2), 64'd0);
        e = exp_q.pop_back();
        @(posedge CLK); #1;
        RESETn = 1'b1; Start = 1'b0;
        run_op(2'b10, 32'd1000, -32'd7);

        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom), pick(), pick());
        end

        repeat (5) @(negedge CLK);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
